// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory between an instruction cache and a data cache.
// The memory request for a grant is latched on entry and held unchanged until the memory completes.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;   // 1: data port was granted most recently
  logic              req_i, req_d;
  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  assign req_i = I_READ;
  assign req_d = D_READ | D_WRITE;

  assign I_BUSYWAIT = req_i & (state != DONE_I);
  assign D_BUSYWAIT = req_d & (state != DONE_D);

  // Next state, round-robin pointer and next memory request
  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    mem_read_nxt  = 1'b0;
    mem_write_nxt = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;

    unique case (state)
      IDLE: begin
        if (req_i && (!req_d || last_d)) begin
          state_nxt  = GRANT_I;
          last_d_nxt = 1'b0;
        end else if (req_d) begin
          state_nxt  = GRANT_D;
          last_d_nxt = 1'b1;
        end
      end
      GRANT_I: if (!MEM_BUSYWAIT) state_nxt = DONE_I;
      GRANT_D: if (!MEM_BUSYWAIT) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A grant keeps the request it latched on entry, even if the requester withdraws
    if (state_nxt == state && (state == GRANT_I || state == GRANT_D)) begin
      mem_read_nxt  = MEM_READ;
      mem_write_nxt = MEM_WRITE;
      mem_addr_nxt  = MEM_ADDRESS;
      mem_wdata_nxt = MEM_WRITEDATA;
    end else if (state_nxt == GRANT_I) begin
      mem_read_nxt  = 1'b1;
      mem_addr_nxt  = I_ADDRESS;
    end else if (state_nxt == GRANT_D) begin
      mem_write_nxt = D_WRITE;
      mem_read_nxt  = ~D_WRITE;
      mem_addr_nxt  = D_ADDRESS;
      mem_wdata_nxt = D_WRITEDATA;
    end
  end

  // State, pointer and memory request registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      state         <= state_nxt;
      last_d        <= last_d_nxt;
      MEM_READ      <= mem_read_nxt;
      MEM_WRITE     <= mem_write_nxt;
      MEM_ADDRESS   <= mem_addr_nxt;
      MEM_WRITEDATA <= mem_wdata_nxt;
    end
  end

  // Read data capture on memory completion; a data-port write leaves D_READDATA alone
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      I_READDATA <= '0;
      D_READDATA <= '0;
    end else begin
      if (state == GRANT_I && !MEM_BUSYWAIT) I_READDATA <= MEM_READDATA;
      if (state == GRANT_D && !MEM_BUSYWAIT && !MEM_WRITE) D_READDATA <= MEM_READDATA;
    end
  end

endmodule
